// File: rtl/decode_queue_if.sv
// Fetch-to-read handshake bundle for the decode queue: fetch offer, redirect/stall controls,
// and the registered decode result presented to the read stage.
interface decode_queue_if #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instruction;
  logic [XLEN-1:0]     in_pc;
  logic [3:0]          flags;
  logic                flush;
  logic                out_hold;
  logic                out_valid;
  logic                out_cond;
  logic [XLEN-1:0]     out_pc;
  logic [3:0]          out_operation;
  logic [REG_BITS-1:0] out_destination;
  logic [REG_BITS-1:0] out_left;
  logic [REG_BITS-1:0] out_right;
  logic [REG_BITS-1:0] out_address;
  logic [1:0]          out_adj_op;
  logic [XLEN-1:0]     out_adj_value;
  logic                out_read_mem;
  logic                out_write_mem;
  logic                pc_changing;

  modport master (
    output in_valid, in_instruction, in_pc, flags, flush, out_hold,
    input  in_ready, out_valid, out_cond, out_pc, out_operation, out_destination,
           out_left, out_right, out_address, out_adj_op, out_adj_value,
           out_read_mem, out_write_mem, pc_changing
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, flags, flush, out_hold,
    output in_ready, out_valid, out_cond, out_pc, out_operation, out_destination,
           out_left, out_right, out_address, out_adj_op, out_adj_value,
           out_read_mem, out_write_mem, pc_changing
  );
endinterface

// File: rtl/decode_queue.sv
// Decode stage: circular instruction queue, head decode, registered output toward read, and a
// drain mode that stops issue after a PC-writing instruction until fetch redirects with flush.
//  state | meaning
//  RUN   | queue head is decoded and popped into the output registers
//  DRAIN | a PC-writing instruction was issued; no pops or pushes until flush
module decode_queue #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 4,
  parameter int REG_BITS = 5
) (
  input logic          clock,
  input logic          reset,
  decode_queue_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]    FULL     = CNT_W'(DEPTH);
  localparam logic [REG_BITS-1:0] PC_INDEX = '1;
  localparam logic [1:0]          ADJ_ADD  = 2'd0;
  localparam logic [1:0]          ADJ_LEFT = 2'd1;

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_next;

  logic [31:0]      q_instr [DEPTH];
  logic [XLEN-1:0]  q_pc    [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic             ready, push, pop;

  logic [31:0]         head;
  logic                d_cond, d_read, d_write, d_pc_writes;
  logic [3:0]          d_operation;
  logic [REG_BITS-1:0] d_dst, d_left, d_right, d_address;
  logic [1:0]          d_adj_op;
  logic [XLEN-1:0]     d_adj_value;

  logic                o_valid, o_cond, o_read, o_write, o_pc_changing;
  logic [XLEN-1:0]     o_pc, o_adj_value;
  logic [3:0]          o_operation;
  logic [REG_BITS-1:0] o_dst, o_left, o_right, o_address;
  logic [1:0]          o_adj_op;

  // Ready looks only at registered state so fetch never sees a combinational path from read.
  assign ready = (count < FULL) && (state == RUN);
  assign push  = bus.in_valid && ready && !bus.flush;
  assign pop   = (count != '0) && (state == RUN) && !bus.out_hold && !bus.flush;

  always_comb begin
    head        = q_instr[rd_ptr];
    d_cond      = (head[31] == |(head[30:27] & bus.flags));
    d_operation = head[26:23];
    d_dst       = REG_BITS'(head[22:18]);
    d_left      = REG_BITS'(head[16:12]);
    d_right     = REG_BITS'(head[11:7]);
    d_address   = REG_BITS'(head[15:11]);
    d_adj_op    = head[6:5];
    d_adj_value = {{(XLEN-5){head[4]}}, head[4:0]};
    d_read      = 1'b0;
    d_write     = 1'b0;
    if (head[26:23] == 4'd14) begin
      d_left      = '0;
      d_right     = '0;
      d_operation = 4'd10;
      d_adj_op    = ADJ_ADD;
      case (head[17:16])
        2'd0: begin
          d_read      = 1'b1;
          d_adj_value = {{(XLEN-11){head[10]}}, head[10:0]};
        end
        2'd1: d_adj_value = {{(XLEN-16){head[15]}}, head[15:0]};
        2'd2: begin
          d_left      = d_dst;
          d_adj_value = {{(XLEN-16){head[15]}}, head[15:0]};
        end
        default: begin
          d_write     = 1'b1;
          d_left      = d_dst;
          d_adj_op    = ADJ_LEFT;
          d_adj_value = {{(XLEN-11){head[10]}}, head[10:0]};
        end
      endcase
    end else if (head[26:23] == 4'd15) begin
      d_read      = 1'b1;
      d_write     = 1'b1;
      d_address   = REG_BITS'(head[6:2]);
      d_adj_op    = ADJ_ADD;
      d_adj_value = '0;
    end else if (!head[17]) begin
      d_right     = '0;
      d_adj_op    = ADJ_ADD;
      d_adj_value = {{(XLEN-12){head[11]}}, head[11:0]};
    end
    // Stores write memory only, so they never redirect even with PC as the data register.
    d_pc_writes = d_cond && (!d_write || d_read) && (d_dst == PC_INDEX);
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_instr[wr_ptr] <= bus.in_instruction;
      q_pc[wr_ptr]    <= bus.in_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      o_valid       <= 1'b0;
      o_cond        <= 1'b0;
      o_pc          <= '0;
      o_operation   <= '0;
      o_dst         <= '0;
      o_left        <= '0;
      o_right       <= '0;
      o_address     <= '0;
      o_adj_op      <= '0;
      o_adj_value   <= '0;
      o_read        <= 1'b0;
      o_write       <= 1'b0;
      o_pc_changing <= 1'b0;
    end else if (bus.flush) begin
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      o_valid       <= 1'b0;
      o_pc_changing <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (pop) begin
        o_valid       <= 1'b1;
        o_cond        <= d_cond;
        o_pc          <= q_pc[rd_ptr];
        o_operation   <= d_operation;
        o_dst         <= d_dst;
        o_left        <= d_left;
        o_right       <= d_right;
        o_address     <= d_address;
        o_adj_op      <= d_adj_op;
        o_adj_value   <= d_adj_value;
        o_read        <= d_read;
        o_write       <= d_write;
        o_pc_changing <= d_pc_writes;
      end else if (!bus.out_hold) begin
        o_valid       <= 1'b0;
        o_pc_changing <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.flush)                                  state_next = RUN;
    else if (state == RUN && pop && d_pc_writes)    state_next = DRAIN;
  end

  assign bus.in_ready        = ready;
  assign bus.out_valid       = o_valid;
  assign bus.out_cond        = o_cond;
  assign bus.out_pc          = o_pc;
  assign bus.out_operation   = o_operation;
  assign bus.out_destination = o_dst;
  assign bus.out_left        = o_left;
  assign bus.out_right       = o_right;
  assign bus.out_address     = o_address;
  assign bus.out_adj_op      = o_adj_op;
  assign bus.out_adj_value   = o_adj_value;
  assign bus.out_read_mem    = o_read;
  assign bus.out_write_mem   = o_write;
  assign bus.pc_changing     = o_pc_changing;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: expected decodes are queued when words are accepted and
// compared against each fresh emission from the output registers.
module tb_decode_queue;
  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int RB = 5;

  typedef struct packed {
    logic        cond;
    logic [31:0] pc;
    logic [3:0]  op;
    logic [4:0]  dst;
    logic [4:0]  left;
    logic [4:0]  right;
    logic [4:0]  addr;
    logic [1:0]  adj_op;
    logic [31:0] adj;
    logic        rd;
    logic        wr;
    logic        pcch;
  } emit_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  emit_t sb[$];

  always #5 clock = ~clock;

  decode_queue_if #(.XLEN(XLEN), .REG_BITS(RB)) bus ();
  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .REG_BITS(RB)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic c, input logic [3:0] mask, input logic [3:0] op,
                                     input logic [4:0] dst, input logic [17:0] low);
    return {c, mask, op, dst, low};
  endfunction

  function automatic emit_t ref_dec(input logic [31:0] i, input logic [31:0] pc, input logic [3:0] f);
    emit_t e;
    e.cond   = (i[31] == |(i[30:27] & f));
    e.pc     = pc;
    e.op     = i[26:23];
    e.dst    = i[22:18];
    e.left   = i[16:12];
    e.right  = i[11:7];
    e.addr   = i[15:11];
    e.adj_op = i[6:5];
    e.adj    = {{27{i[4]}}, i[4:0]};
    e.rd     = 1'b0;
    e.wr     = 1'b0;
    if (i[26:23] == 4'd14) begin
      e.left = 5'd0; e.right = 5'd0; e.op = 4'd10; e.adj_op = 2'd0;
      case (i[17:16])
        2'd0: begin e.rd = 1'b1; e.adj = {{21{i[10]}}, i[10:0]}; end
        2'd1: e.adj = {{16{i[15]}}, i[15:0]};
        2'd2: begin e.left = i[22:18]; e.adj = {{16{i[15]}}, i[15:0]}; end
        default: begin
          e.wr = 1'b1; e.left = i[22:18]; e.adj_op = 2'd1; e.adj = {{21{i[10]}}, i[10:0]};
        end
      endcase
    end else if (i[26:23] == 4'd15) begin
      e.rd = 1'b1; e.wr = 1'b1; e.addr = i[6:2]; e.adj_op = 2'd0; e.adj = 32'd0;
    end else if (!i[17]) begin
      e.right = 5'd0; e.adj_op = 2'd0; e.adj = {{20{i[11]}}, i[11:0]};
    end
    e.pcch = e.cond && (!e.wr || e.rd) && (e.dst == 5'd31);
    return e;
  endfunction

  function automatic emit_t got_emit();
    emit_t e;
    e.cond = bus.out_cond;            e.pc = bus.out_pc;
    e.op = bus.out_operation;         e.dst = bus.out_destination;
    e.left = bus.out_left;            e.right = bus.out_right;
    e.addr = bus.out_address;         e.adj_op = bus.out_adj_op;
    e.adj = bus.out_adj_value;        e.rd = bus.out_read_mem;
    e.wr = bus.out_write_mem;         e.pcch = bus.pc_changing;
    return e;
  endfunction

  // A fresh emission is any edge taken without hold that leaves out_valid high.
  task automatic step();
    logic h;
    emit_t e;
    h = bus.out_hold;
    @(posedge clock);
    #1;
    if (!h && bus.out_valid) begin
      if (sb.size() == 0) check("spurious_emit", bus.out_valid, 1'b0);
      else begin
        e = sb.pop_front();
        check("emit", got_emit(), e);
      end
    end
  endtask

  task automatic push_word(input logic [31:0] i, input logic [31:0] pc, input bit expect_emit);
    bus.in_valid = 1'b1;
    bus.in_instruction = i;
    bus.in_pc = pc;
    check("push_in_ready", bus.in_ready, 1'b1);
    if (expect_emit) sb.push_back(ref_dec(i, pc, bus.flags));
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    logic [31:0] w4, w5, ldi, st, cx;
    bus.in_valid = 1'b0; bus.in_instruction = '0; bus.in_pc = '0;
    bus.flags = 4'b0; bus.flush = 1'b0; bus.out_hold = 1'b0;
    reset = 1'b1;
    step(); step();
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_pc_changing", bus.pc_changing, 1'b0);
    check("reset_adj_value", bus.out_adj_value, 32'd0);
    check("reset_in_ready", bus.in_ready, 1'b1);
    reset = 1'b0;

    // reset while holding with a full queue
    bus.out_hold = 1'b1;
    for (int k = 0; k < 4; k++) push_word(mk(1'b0, 4'd0, 4'd1, 5'd2, 18'h0), 32'h40 + 4 * k, 1'b0);
    check("full_in_ready", bus.in_ready, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst_hold_out_valid", bus.out_valid, 1'b0);
    check("rst_hold_in_ready", bus.in_ready, 1'b1);
    bus.out_hold = 1'b0;
    step(); step();
    check("rst_queue_empty", bus.out_valid, 1'b0);

    // latency and 12-bit sign extension
    push_word(32'h7000_1FFF, 32'h100, 1'b1);
    check("lat_edge1_valid", bus.out_valid, 1'b0);
    step();
    check("lat_edge2_valid", bus.out_valid, 1'b1);
    check("sext12_adj", bus.out_adj_value, 32'hFFFF_FFFF);
    check("imm_right_zero", bus.out_right, 5'd0);
    check("imm_adj_op_add", bus.out_adj_op, 2'd0);
    step();
    check("idle_valid_drop", bus.out_valid, 1'b0);

    // condition evaluation; annulled PC write must not drain
    bus.flags = 4'b0001;
    push_word(mk(1'b1, 4'b0001, 4'd3, 5'd7, {1'b1, 5'd4, 5'd5, 7'h2A}), 32'h200, 1'b1);
    step();
    check("cond_pass", bus.out_cond, 1'b1);
    push_word(mk(1'b1, 4'b1000, 4'd0, 5'd31, 18'h00123), 32'h204, 1'b1);
    step();
    check("cond_annul", bus.out_cond, 1'b0);
    check("annul_valid", bus.out_valid, 1'b1);
    check("annul_no_pcch", bus.pc_changing, 1'b0);
    push_word(mk(1'b0, 4'd0, 4'd2, 5'd6, {1'b1, 5'd1, 5'd2, 7'h55}), 32'h208, 1'b1);
    wait_empty(10);
    bus.flags = 4'b0000;

    // hold back-pressure, freeze and in-order release
    push_word(mk(1'b0, 4'd0, 4'd5, 5'd9, {1'b1, 5'd3, 5'd4, 7'h11}), 32'h300, 1'b1);
    step();
    check("pre_hold_valid", bus.out_valid, 1'b1);
    bus.out_hold = 1'b1;
    for (int k = 0; k < 4; k++)
      push_word(mk(1'b0, 4'd0, 4'(k + 1), 5'(k + 10), 18'(k * 97 + 5)), 32'h400 + 4 * k, 1'b1);
    check("hold_full_ready", bus.in_ready, 1'b0);
    w4 = mk(1'b0, 4'd0, 4'd6, 5'd20, 18'h0F80);
    w5 = mk(1'b0, 4'd0, 4'd7, 5'd21, {1'b1, 5'd8, 5'd9, 7'h7F});
    bus.in_valid = 1'b1; bus.in_instruction = w4; bus.in_pc = 32'h410;
    repeat (6) step();
    check("hold_full_ready2", bus.in_ready, 1'b0);
    check("hold_frozen_pc", bus.out_pc, 32'h300);
    check("hold_frozen_valid", bus.out_valid, 1'b1);
    bus.in_valid = 1'b0; bus.out_hold = 1'b0;
    wait_empty(20);
    push_word(w4, 32'h410, 1'b1);
    push_word(w5, 32'h414, 1'b1);
    wait_empty(10);

    // drain on a PC-writing ldi, recovery by flush
    ldi = mk(1'b0, 4'd0, 4'd14, 5'd31, {2'b01, 16'h8001});
    push_word(ldi, 32'h500, 1'b1);
    bus.in_valid = 1'b1; bus.in_instruction = w5; bus.in_pc = 32'h504;
    step();
    check("drain_pcch", bus.pc_changing, 1'b1);
    check("drain_ldi_adj", bus.out_adj_value, 32'hFFFF_8001);
    bus.in_instruction = w4; bus.in_pc = 32'h508;
    check("drain_in_ready", bus.in_ready, 1'b0);
    step();
    check("drain_valid_drop", bus.out_valid, 1'b0);
    check("drain_pcch_drop", bus.pc_changing, 1'b0);
    repeat (3) step();
    check("drain_stall_valid", bus.out_valid, 1'b0);
    check("drain_stall_ready", bus.in_ready, 1'b0);
    bus.flush = 1'b1; bus.in_pc = 32'h50C;
    step();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_in_ready", bus.in_ready, 1'b1);
    check("flush_out_valid", bus.out_valid, 1'b0);
    repeat (3) step();
    check("flush_discard", bus.out_valid, 1'b0);
    push_word(mk(1'b0, 4'd0, 4'd8, 5'd3, {1'b1, 5'd6, 5'd7, 7'h01}), 32'h600, 1'b1);
    wait_empty(10);

    // store to PC does not redirect, cx to PC does
    st = mk(1'b0, 4'd0, 4'd14, 5'd31, {2'b11, 16'h0C00});
    push_word(st, 32'h700, 1'b1);
    step();
    check("st_pcch", bus.pc_changing, 1'b0);
    check("st_write", bus.out_write_mem, 1'b1);
    check("st_adj", bus.out_adj_value, 32'hFFFF_FC00);
    cx = mk(1'b0, 4'd0, 4'd15, 5'd31, {1'b0, 5'd1, 5'd2, 7'b0111100});
    push_word(cx, 32'h704, 1'b1);
    step();
    check("cx_pcch", bus.pc_changing, 1'b1);
    check("cx_rw", {bus.out_read_mem, bus.out_write_mem}, 2'b11);
    check("cx_address", bus.out_address, 5'd15);

    // flush overrides hold
    bus.out_hold = 1'b1; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_hold_valid", bus.out_valid, 1'b0);
    check("flush_hold_pcch", bus.pc_changing, 1'b0);
    bus.out_hold = 1'b0;
    push_word(mk(1'b0, 4'd0, 4'd4, 5'd1, 18'h00800), 32'h800, 1'b1);
    wait_empty(10);
    step();
    check("final_idle", bus.out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
